// File: rtl/mcu_pkg.sv
// Shared definitions for the 8-bit MCU: sequencer states, instruction fields,
// status-register bit positions and the ALU mode codes shared with the ALU.
package mcu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2
  } state_e;

  // Instruction class, IR[11:10]
  typedef enum logic [1:0] {
    CLS_CTRL = 2'b00,
    CLS_LDI  = 2'b01,
    CLS_ALU  = 2'b10,
    CLS_STA  = 2'b11
  } class_e;

  // Control sub-op, IR[9:8] when class is CLS_CTRL
  typedef enum logic [1:0] {
    CTL_NOP = 2'b00,
    CTL_JMP = 2'b01,
    CTL_JZ  = 2'b10,
    CTL_JC  = 2'b11
  } ctl_e;

  // Status register layout {Z,C,S,O}
  localparam int SR_Z = 3;
  localparam int SR_C = 2;
  localparam int SR_S = 1;
  localparam int SR_O = 0;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_NOT = 4'h5;
  localparam logic [3:0] ALU_SHL = 4'h6;
  localparam logic [3:0] ALU_SHR = 4'h7;
  localparam logic [3:0] ALU_ROL = 4'h8;
  localparam logic [3:0] ALU_ROR = 4'h9;
  localparam logic [3:0] ALU_INC = 4'hA;
  localparam logic [3:0] ALU_DEC = 4'hB;
  localparam logic [3:0] ALU_ADC = 4'hC;
  localparam logic [3:0] ALU_SBB = 4'hD;
  localparam logic [3:0] ALU_MOV = 4'hE;
  localparam logic [3:0] ALU_CMP = 4'hF;

  typedef struct packed {
    class_e     cls;
    ctl_e       ctl;
    logic       dest;   // ALU write-back: 0 = ACC, 1 = DMEM[rsel]
    logic [3:0] mode;
    logic [3:0] rsel;
    logic [7:0] imm;
  } instr_t;

  // IR[9] is reserved for ALU ops and simply not extracted
  function automatic instr_t decode_instr(input logic [11:0] ir);
    instr_t d;
    d.cls  = class_e'(ir[11:10]);
    d.ctl  = ctl_e'(ir[9:8]);
    d.dest = ir[8];
    d.mode = ir[7:4];
    d.rsel = ir[3:0];
    d.imm  = ir[7:0];
    return d;
  endfunction

endpackage

// File: rtl/mcu_control_unit_if.sv
// Program-ROM and ALU bus between the control unit (master) and the
// ROM/ALU side (slave).
interface mcu_control_unit_if;
  logic [7:0]  prog_addr;
  logic [11:0] prog_data;
  logic [7:0]  alu_operand1;
  logic [7:0]  alu_operand2;
  logic        alu_enable;
  logic [3:0]  alu_mode;
  logic [3:0]  alu_cflags;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flags;

  modport master (
    output prog_addr, alu_operand1, alu_operand2, alu_enable, alu_mode, alu_cflags,
    input  prog_data, alu_out, alu_flags
  );

  modport slave (
    input  prog_addr, alu_operand1, alu_operand2, alu_enable, alu_mode, alu_cflags,
    output prog_data, alu_out, alu_flags
  );
endinterface

// File: rtl/mcu_regfile.sv
// 16x8 data register file: synchronous write, combinational read and a
// synchronous active-low clear of every entry.
module mcu_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] rd_vec [16];

  // Entries are discrete registers because reset must clear all of them at once
  for (genvar gi = 0; gi < 16; gi++) begin : g_entry
    logic [7:0] entry_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        entry_reg <= 8'h00;
      end else if (we && (waddr == 4'(gi))) begin
        entry_reg <= wdata;
      end
    end

    assign rd_vec[gi] = entry_reg;
  end

  assign rdata = rd_vec[raddr];

endmodule

// File: rtl/mcu_control_unit.sv
// Three-cycle fetch/decode/execute sequencer of the 8-bit MCU: owns PC, IR,
// ACC, SR and the data register file, and drives the ALU.
module mcu_control_unit
  import mcu_pkg::*;
#(
  parameter int                 PROG_AW  = 8,   // tied to the instruction encoding
  parameter logic [PROG_AW-1:0] PC_RESET = 8'h00
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  mcu_control_unit_if.master  bus,
  output logic [7:0]          acc,
  output logic [3:0]          status,
  output logic [PROG_AW-1:0]  pc,
  output logic                instr_done
);

  state_e             state_reg, state_next;
  logic [PROG_AW-1:0] pc_reg;
  logic [11:0]        ir_reg;
  logic [7:0]         acc_reg;
  logic [3:0]         sr_reg;
  instr_t             dec;

  logic               rf_we;
  logic [7:0]         rf_wdata;
  logic [7:0]         rf_rdata;
  logic               branch_taken;

  always_comb dec = decode_instr(ir_reg);

  mcu_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .waddr (dec.rsel),
    .wdata (rf_wdata),
    .raddr (dec.rsel),
    .rdata (rf_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH:   if (en) state_next = ST_DECODE;
      ST_DECODE:  state_next = ST_EXECUTE;
      ST_EXECUTE: state_next = ST_FETCH;
      default:    state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    bus.prog_addr    = pc_reg;
    bus.alu_cflags   = sr_reg;
    bus.alu_operand1 = 8'h00;
    bus.alu_operand2 = 8'h00;
    bus.alu_enable   = 1'b0;
    bus.alu_mode     = 4'h0;
    instr_done       = 1'b0;
    rf_we            = 1'b0;
    rf_wdata         = acc_reg;
    branch_taken     = 1'b0;
    if (state_reg == ST_EXECUTE) begin
      instr_done = 1'b1;
      case (dec.cls)
        CLS_CTRL: begin
          case (dec.ctl)
            CTL_JMP: branch_taken = 1'b1;
            CTL_JZ:  branch_taken = sr_reg[SR_Z];
            CTL_JC:  branch_taken = sr_reg[SR_C];
            default: branch_taken = 1'b0;
          endcase
        end
        CLS_ALU: begin
          bus.alu_enable   = 1'b1;
          bus.alu_operand1 = acc_reg;
          bus.alu_operand2 = rf_rdata;
          bus.alu_mode     = dec.mode;
          rf_we            = dec.dest;
          rf_wdata         = bus.alu_out;
        end
        CLS_STA: rf_we = 1'b1;
        default: ;
      endcase
    end
  end

  // PC was already advanced in DECODE, so a not-taken branch needs no action
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg  <= PC_RESET;
      ir_reg  <= 12'h000;
      acc_reg <= 8'h00;
      sr_reg  <= 4'h0;
    end else begin
      case (state_reg)
        ST_DECODE: begin
          ir_reg <= bus.prog_data;
          pc_reg <= pc_reg + PROG_AW'(1);
        end
        ST_EXECUTE: begin
          case (dec.cls)
            CLS_CTRL: if (branch_taken) pc_reg <= dec.imm;
            CLS_LDI:  acc_reg <= dec.imm;
            CLS_ALU: begin
              sr_reg <= bus.alu_flags;
              if (!dec.dest) acc_reg <= bus.alu_out;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign acc    = acc_reg;
  assign status = sr_reg;
  assign pc     = pc_reg;

endmodule

// File: tb/tb_mcu_control_unit.sv
// Bench for mcu_control_unit: registered ROM and ADD/SUB ALU models, a table
// of program steps checked through a scoreboard, plus reset corner sequences.
module tb_mcu_control_unit;
  import mcu_pkg::*;

  typedef struct {
    logic [11:0] instr;
    logic [7:0]  acc;
    logic [3:0]  sr;
    logic [7:0]  pc;
    logic        alu_en;
    logic [3:0]  mode;
    logic [7:0]  op1;
    logic [7:0]  op2;
  } vec_t;

  localparam int NV = 18;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] acc;
  logic [3:0] status;
  logic [7:0] pc;
  logic       instr_done;

  mcu_control_unit_if bus ();

  mcu_control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bus        (bus),
    .acc        (acc),
    .status     (status),
    .pc         (pc),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [256];
  always @(posedge clk) bus.prog_data <= rom[bus.prog_addr];

  // Reference ALU: flags {Z,C,S,O}, carry on SUB means "no borrow"
  always_comb begin
    logic [8:0] s;
    logic       o;
    s = 9'h000;
    o = 1'b0;
    case (bus.alu_mode)
      ALU_ADD: begin
        s = {1'b0, bus.alu_operand1} + {1'b0, bus.alu_operand2};
        o = (bus.alu_operand1[7] == bus.alu_operand2[7]) && (s[7] != bus.alu_operand1[7]);
      end
      ALU_SUB: begin
        s = {1'b0, bus.alu_operand1} + {1'b0, ~bus.alu_operand2} + 9'd1;
        o = (bus.alu_operand1[7] != bus.alu_operand2[7]) && (s[7] != bus.alu_operand1[7]);
      end
      default: s = {1'b0, bus.alu_operand1};
    endcase
    bus.alu_out   = s[7:0];
    bus.alu_flags = {(s[7:0] == 8'h00), s[8], s[7], o};
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs [NV];
  vec_t exp_q [$];
  vec_t mv;
  logic mon_en = 1'b0;
  logic [3:0] model_sr = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Scoreboard: ALU side checked in EXECUTE, architectural state in the next FETCH
  always @(negedge clk) begin
    if (mon_en && instr_done) begin
      if (exp_q.size() == 0) begin
        chk("spurious instr_done", 32'(instr_done), 32'(0));
      end else begin
        mv = exp_q.pop_front();
        $display("instr %03h: alu_en=%0b mode=%0h op1=%02h op2=%02h", mv.instr,
                 bus.alu_enable, bus.alu_mode, bus.alu_operand1, bus.alu_operand2);
        chk("alu_enable", 32'(bus.alu_enable), 32'(mv.alu_en));
        chk("alu_mode", 32'(bus.alu_mode), 32'(mv.mode));
        chk("alu_operand1", 32'(bus.alu_operand1), 32'(mv.op1));
        chk("alu_operand2", 32'(bus.alu_operand2), 32'(mv.op2));
        chk("alu_cflags", 32'(bus.alu_cflags), 32'(model_sr));
        @(negedge clk);
        chk("acc", 32'(acc), 32'(mv.acc));
        chk("status", 32'(status), 32'(mv.sr));
        chk("pc", 32'(pc), 32'(mv.pc));
        chk("prog_addr", 32'(bus.prog_addr), 32'(mv.pc));
        chk("instr_done in fetch", 32'(instr_done), 32'(0));
        model_sr = mv.sr;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   addr;
    int   cyc;
    int   n;
    logic done;

    //          instr    acc    sr    pc    en    mode  op1    op2
    vecs[0]  = '{12'h47F, 8'h7F, 4'h0, 8'h01, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[1]  = '{12'hC01, 8'h7F, 4'h0, 8'h02, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[2]  = '{12'h401, 8'h01, 4'h0, 8'h03, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[3]  = '{12'h801, 8'h80, 4'h3, 8'h04, 1'b1, 4'h0, 8'h01, 8'h7F};
    vecs[4]  = '{12'h405, 8'h05, 4'h3, 8'h05, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[5]  = '{12'hC02, 8'h05, 4'h3, 8'h06, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[6]  = '{12'h812, 8'h00, 4'hC, 8'h07, 1'b1, 4'h1, 8'h05, 8'h05};
    vecs[7]  = '{12'h310, 8'h00, 4'hC, 8'h10, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[8]  = '{12'h220, 8'h00, 4'hC, 8'h20, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[9]  = '{12'h403, 8'h03, 4'hC, 8'h21, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[10] = '{12'hFF3, 8'h03, 4'hC, 8'h22, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[11] = '{12'h402, 8'h02, 4'hC, 8'h23, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[12] = '{12'h903, 8'h02, 4'h0, 8'h24, 1'b1, 4'h0, 8'h02, 8'h03};
    vecs[13] = '{12'h330, 8'h02, 4'h0, 8'h25, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[14] = '{12'hA03, 8'h07, 4'h0, 8'h26, 1'b1, 4'h0, 8'h02, 8'h05};
    vecs[15] = '{12'h240, 8'h07, 4'h0, 8'h27, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[16] = '{12'h1FF, 8'h07, 4'h0, 8'hFF, 1'b0, 4'h0, 8'h00, 8'h00};
    vecs[17] = '{12'h000, 8'h07, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 8'h00};

    // Lay the program out along its own execution path
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    addr = 0;
    for (int i = 0; i < NV; i++) begin
      rom[addr] = vecs[i].instr;
      addr = int'(vecs[i].pc);
    end

    // Reset and idle
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset pc", 32'(pc), 32'(0));
    chk("reset alu_enable", 32'(bus.alu_enable), 32'(0));
    chk("reset alu_cflags", 32'(bus.alu_cflags), 32'(0));
    chk("reset instr_done", 32'(instr_done), 32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      $display("idle cycle %0d: pc=%02h prog_addr=%02h done=%0b", i, pc, bus.prog_addr, instr_done);
      chk("idle prog_addr", 32'(bus.prog_addr), 32'(0));
      chk("idle instr_done", 32'(instr_done), 32'(0));
    end
    chk("idle acc", 32'(acc), 32'(0));
    chk("idle status", 32'(status), 32'(0));
    chk("idle pc", 32'(pc), 32'(0));

    // Table-driven program walk
    mon_en = 1'b1;
    for (int i = 0; i < NV; i++) exp_q.push_back(vecs[i]);
    en   = 1'b1;
    cyc  = 1;
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      cyc++;
      if (instr_done) begin
        n++;
        if (n == 4) chk("4th instr_done cycle", 32'(cyc), 32'(12));
        if (n == NV) begin
          en   = 1'b0;
          done = 1'b1;
        end
      end
    end
    chk("program completed", 32'(n), 32'(NV));
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'(0));
    chk("hold with en=0 pc", 32'(pc), 32'(0));
    mon_en = 1'b0;

    // Reset during EXECUTE of STA 5 with ACC=AA
    rom[8'h00] = 12'h4AA;
    rom[8'h01] = 12'hC05;
    en   = 1'b1;
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (instr_done) begin
        n++;
        if (n == 2) begin
          $display("abort STA 5: acc=%02h pc=%02h", acc, pc);
          chk("acc before abort", 32'(acc), 32'hAA);
          rst_n = 1'b0;
          en    = 1'b0;
          done  = 1'b1;
        end
      end
    end
    chk("reached STA execute", 32'(n), 32'(2));
    @(negedge clk);
    chk("abort pc", 32'(pc), 32'(0));
    chk("abort acc", 32'(acc), 32'(0));
    chk("abort alu_enable", 32'(bus.alu_enable), 32'(0));
    chk("abort instr_done", 32'(instr_done), 32'(0));

    // Back in FETCH: ADD r5 must execute on cycle 3 and read DMEM[5]=00
    rst_n = 1'b1;
    rom[8'h00] = 12'h805;
    en   = 1'b1;
    cyc  = 1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      cyc++;
      if (instr_done) begin
        $display("post-abort ADD r5: cycle=%0d op1=%02h op2=%02h", cyc, bus.alu_operand1, bus.alu_operand2);
        chk("post-abort execute cycle", 32'(cyc), 32'(3));
        chk("DMEM[5] after abort", 32'(bus.alu_operand2), 32'(0));
        chk("post-abort operand1", 32'(bus.alu_operand1), 32'(0));
        en   = 1'b0;
        done = 1'b1;
      end
    end
    chk("post-abort instruction ran", 32'(done), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_control_unit.md
Name: mcu_control_unit

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit microcontroller; the stage directly upstream of the ALU.
- Fetches 12-bit instructions from an external synchronous program ROM.
- Holds PC, IR, accumulator (ACC), a 16x8 data register file (DMEM) and a 4-bit status register (SR).
- Drives the ALU operand/mode/enable inputs, then consumes ALU result and flags for write-back and conditional branches.

Parameters:
- PC_RESET, 8'h00, PC value loaded on reset.
- PROG_AW, 8, program address width. Fixed by the instruction encoding; must not be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  run enable; sampled only in FETCH.
- prog_addr  out  8  ROM address. Registered ROM: data appears on prog_data the cycle after the address is sampled.
- prog_data  in  12  ROM read data.
- alu_operand1  out  8  ACC during ALU execute, else 0.
- alu_operand2  out  8  DMEM[IR[3:0]] during ALU execute, else 0.
- alu_enable  out  1  high only in EXECUTE of an ALU-class instruction.
- alu_mode  out  4  IR[7:4] during ALU execute, else 0.
- alu_cflags  out  4  current SR.
- alu_out  in  8  ALU result.
- alu_flags  in  4  ALU flags {Z,C,S,O}.
- acc  out  8  accumulator.
- status  out  4  SR {Z,C,S,O}.
- pc  out  8  program counter.
- instr_done  out  1  one-cycle pulse in each EXECUTE cycle.

Behaviour:
Reset (rst_n low at a clk edge):
- PC=PC_RESET, IR=0, ACC=0, SR=0, all 16 DMEM entries=0, state=FETCH.
- All ALU-side outputs 0; instr_done=0.
- Reset during any state aborts the instruction: no DMEM/ACC/SR/PC update from it.

FSM (3 cycles per instruction):
- FETCH: prog_addr=PC. If en=1 go to DECODE; else stay in FETCH and hold all state.
- DECODE: IR<=prog_data; PC<=PC+1 (wraps 8'hFF->8'h00); go to EXECUTE.
- EXECUTE: act on IR (below); instr_done=1; go to FETCH unconditionally (en is ignored).

Encoding by IR[11:10]:
- 00 control, selected by IR[9:8], target IR[7:0]:
  - 00 NOP.
  - 01 JMP: PC<=target.
  - 10 JZ: PC<=target if SR.Z=1.
  - 11 JC: PC<=target if SR.C=1.
  - Not taken: PC keeps the value incremented in DECODE.
- 01 LDI: ACC<=IR[7:0]. SR unchanged.
- 10 ALU op: mode=IR[7:4], dest=IR[8], reg=IR[3:0].
  - alu_enable=1; operands as listed under Ports.
  - At the end of EXECUTE: dest=0 writes ACC<=alu_out; dest=1 writes DMEM[reg]<=alu_out. SR<=alu_flags.
  - IR[9] reserved, ignored.
- 11 STA: DMEM[IR[3:0]]<=ACC. SR unchanged. IR[9:4] ignored.

Timing and width rules:
- Branch flag tests use the SR value held at entry to EXECUTE.
- DMEM read is combinational. Write-then-read of the same entry is visible from the next instruction on.
- All arithmetic is 8-bit modulo. PC overflow wraps silently.

Decomposition:
- Shared package mcu_pkg:
  - State encoding (FETCH, DECODE, EXECUTE).
  - Class codes, control sub-op codes, SR bit indices (Z=3, C=2, S=1, O=0).
  - ALU mode constants 4'h0-4'hF, shared with the ALU.
- One natural sub-module: mcu_regfile (16x8, sync write, async read, sync active-low clear).
- FSM and decode stay in the top.

Test Plan:
- Reset/idle:
  - Hold rst_n=0 for 2 cycles, then release with en=0 for 5 cycles -> pc=00, acc=00, status=0, prog_addr=00 held, instr_done never pulses.
- Signed-overflow ADD:
  - ROM 0x47F (LDI 7F), 0xC01 (STA 1), 0x401 (LDI 01), 0x801 (ADD r1 -> ACC), en=1.
  - Expect acc=80 and status=4'b0011 after the 4th instr_done, which occurs on the 12th cycle after start.
  - In the ADD EXECUTE cycle: alu_mode=0, alu_operand1=01, alu_operand2=7F, alu_enable=1.
- Zero result and taken branch:
  - ROM 0x405, 0xC02, 0x812 (SUB r2), 0x220 (JZ 20).
  - Expect acc=00, status=4'b1100 after SUB; prog_addr=20 in the next FETCH after JZ.
- Not-taken branch and memory destination:
  - With SR.C=0, execute 0x330 -> next prog_addr = old pc+1.
  - 0x903 (ADD, dest=DMEM r3) with ACC=02, r3=03 -> r3=05, acc unchanged.
- PC wrap:
  - Start at pc=FF with a NOP -> next prog_addr=00.
- Reset mid-instruction:
  - Drive rst_n=0 during the EXECUTE of STA 5 with ACC=AA -> DMEM[5] stays 00, pc=00, state=FETCH, alu_enable=0.
